// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MIPS data-memory access unit.
package mips_mem_pkg;
  localparam int MEM_BYTES_DEFAULT = 8192;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_RESP = 2'd1,
    RMW_WRITE = 2'd2
  } state_e;
endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering: extract+extend for loads, lane merge for sub-word stores.
module load_store_align
  import mips_mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offs,
  input  size_e       size,
  input  logic        sgn,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic [31:0] mask, lane;
  logic [1:0]  lane_idx, span;
  logic [4:0]  shamt;

  always_comb begin
    mask = 32'hFFFF_FFFF;
    span = 2'd0;
    case (size)
      SZ_BYTE: begin mask = 32'h0000_00FF; span = 2'd3; end
      SZ_HALF: begin mask = 32'h0000_FFFF; span = 2'd2; end
      default: ;
    endcase
    // Big-endian puts lane 0 in the top byte, so count the shift from the MSB side.
    lane_idx = BIG_ENDIAN ? (span - offs) : offs;
    shamt    = (size == SZ_BYTE || size == SZ_HALF) ? {lane_idx, 3'b000} : 5'd0;
    lane     = (word >> shamt) & mask;
    case (size)
      SZ_BYTE: load_data = {{24{sgn & lane[7]}}, lane[7:0]};
      SZ_HALF: load_data = {{16{sgn & lane[15]}}, lane[15:0]};
      default: load_data = lane;
    endcase
    merged = (word & ~(mask << shamt)) | ((wdata & mask) << shamt);
  end
endmodule

// File: rtl/mem_access_unit.sv
// Turns byte/half/word loads and stores into word DMem accesses; sub-word stores use read-modify-write.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int MEM_BYTES  = MEM_BYTES_DEFAULT,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        ready,
  output logic        load_valid,
  output logic [31:0] load_data,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
);
  state_e      state_q, state_d;
  size_e       size_q, size_d, req_sz;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, load_data_q, load_data_d;
  logic        sgn_q, sgn_d, load_valid_q, load_valid_d, err_q, err_d;
  logic        accept, bad;
  logic [31:0] ext_data, merged;

  assign req_sz     = size_e'(req_size);
  assign ready      = (state_q == IDLE) && !rst;
  assign accept     = req_valid && ready;
  assign load_valid = load_valid_q;
  assign load_data  = load_data_q;
  assign err        = err_q;

  always_comb begin
    bad = (req_sz == SZ_ILL)
       || (req_sz == SZ_HALF && req_addr[0])
       || (req_sz == SZ_WORD && req_addr[1:0] != 2'b00)
       || (req_addr >= 32'(MEM_BYTES));
  end

  load_store_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
    .word      (mem_dout),
    .wdata     (wdata_q),
    .offs      (addr_q[1:0]),
    .size      (size_q),
    .sgn       (sgn_q),
    .load_data (ext_data),
    .merged    (merged)
  );

  // Memory side: word stores go straight through in the accept cycle; everything else reads first.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = addr_q;
    mem_din   = 32'd0;
    case (state_q)
      IDLE: if (accept && !bad) begin
        mem_addr = req_addr;
        if (req_write && req_sz == SZ_WORD) begin
          mem_write = 1'b1;
          mem_din   = req_wdata;
        end else begin
          mem_read = 1'b1;
        end
      end
      RMW_WRITE: if (!rst) begin
        mem_write = 1'b1;
        mem_din   = merged;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    sgn_d        = sgn_q;
    wdata_d      = wdata_q;
    load_data_d  = load_data_q;
    load_valid_d = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        addr_d  = req_addr;
        size_d  = req_sz;
        sgn_d   = req_signed;
        wdata_d = req_wdata;
        if (bad)                     err_d   = 1'b1;
        else if (!req_write)         state_d = LOAD_RESP;
        else if (req_sz != SZ_WORD)  state_d = RMW_WRITE;
      end
      LOAD_RESP: begin
        load_data_d  = ext_data;
        load_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= 32'd0;
      size_q       <= SZ_BYTE;
      sgn_q        <= 1'b0;
      wdata_q      <= 32'd0;
      load_data_q  <= 32'd0;
      load_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      wdata_q      <= wdata_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      err_q        <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-addressed golden memory model, directed table, corner sequences, random traffic.
module tb_mem_access_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        ready, load_valid, err, mem_read, mem_write;
  logic [31:0] load_data, mem_addr, mem_din, mem_dout;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_BYTES(8192), .BIG_ENDIAN(1'b0)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .ready(ready), .load_valid(load_valid),
    .load_data(load_data), .err(err), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_read(mem_read), .mem_write(mem_write), .mem_dout(mem_dout)
  );

  // Word-wide DMem with registered read.
  logic [31:0] dmem [0:2047];
  always @(posedge clk) begin
    if (mem_write) dmem[mem_addr[12:2]] <= mem_din;
    if (mem_read)  mem_dout <= dmem[mem_addr[12:2]];
  end

  // Reference: byte-addressed little-endian memory plus expected-event schedule.
  logic [7:0]  gold [0:8191];
  int          checks = 0, failures = 0, c = 0;
  int          lv_due = -1, err_due = -1, busy_c = -1, rmw_c = -1, rmw_n = 0;
  logic [31:0] lv_val = 0, m_ld = 0, rmw_a = 0, rmw_wd = 0;
  logic        seen_lv = 0, seen_err = 0;
  logic [31:0] seen_ld = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, c);
    end
  endtask

  function automatic logic [31:0] gold_rd(input int a, input int n);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(gold[a+i]) << (8*i));
    return v;
  endfunction

  task automatic gold_wr(input int a, input int n, input logic [31:0] d);
    for (int i = 0; i < n; i++) gold[a+i] = 8'((d >> (8*i)) & 32'hFF);
  endtask

  function automatic logic [31:0] model_load(input int a, input int n, input logic sg);
    logic [31:0] v = gold_rd(a, n);
    if (sg && n < 4 && v[8*n-1]) v = v - (32'd1 << (8*n));
    return v;
  endfunction

  // One clock cycle: check registered outputs, drive inputs, check ready/memory side, advance model.
  task automatic step(input logic r, input logic v, input logic w, input logic [1:0] sz,
                      input logic sg, input logic [31:0] a, input logic [31:0] wd);
    logic er, ew, acc, bad_r;
    logic [31:0] ea, ed;
    int n;
    @(negedge clk);
    c++;
    if (lv_due == c) m_ld = lv_val;
    chk("load_valid", {31'd0, load_valid}, {31'd0, lv_due == c});
    chk("load_data", load_data, m_ld);
    chk("err", {31'd0, err}, {31'd0, err_due == c});
    if (load_valid) begin seen_lv = 1; seen_ld = load_data; end
    if (err) seen_err = 1;
    rst = r; req_valid = v; req_write = w; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    #1;
    chk("ready", {31'd0, ready}, {31'd0, !r && busy_c != c});
    er = 0; ew = 0; ea = 0; ed = 0;
    acc = v && !r && busy_c != c;
    if (!r && rmw_c == c) begin
      gold_wr(int'(rmw_a), rmw_n, rmw_wd);
      ew = 1; ea = rmw_a; ed = gold_rd(int'(rmw_a & ~32'd3), 4);
    end
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    bad_r = (sz == 2'd3) || (a % n != 0) || (a >= 32'd8192);
    if (acc) begin
      if (bad_r) err_due = c + 1;
      else if (w && n == 4) begin
        gold_wr(int'(a), 4, wd);
        ew = 1; ea = a; ed = wd;
      end else begin
        er = 1; ea = a; busy_c = c + 1;
        if (w) begin rmw_c = c + 1; rmw_a = a; rmw_n = n; rmw_wd = wd; end
        else begin lv_due = c + 2; lv_val = model_load(int'(a), n, sg); end
      end
    end
    chk("mem_read", {31'd0, mem_read}, {31'd0, er});
    chk("mem_write", {31'd0, mem_write}, {31'd0, ew});
    chk("mem_din", mem_din, ew ? ed : 32'd0);
    if (er || ew) chk("mem_addr", mem_addr, ea);
    if (r) begin
      lv_due = -1; err_due = -1; busy_c = -1; rmw_c = -1; m_ld = 0;
    end
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 2'd0, 0, 32'd0, 32'd0);
  endtask

  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
    seen_lv = 0; seen_err = 0; seen_ld = 0;
    step(0, 1, w, sz, sg, a, wd);
    idle(3);
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a, wd;
    logic        xerr, xlv;
    logic [31:0] xd;
  } vec_t;
  vec_t tbl [13];

  initial begin
    for (int i = 0; i < 2048; i++) dmem[i] = 32'd0;
    for (int i = 0; i < 8192; i++) gold[i] = 8'd0;
    dmem[32'h100 >> 2] = 32'h8899AABB;
    gold[32'h100] = 8'hBB; gold[32'h101] = 8'hAA; gold[32'h102] = 8'h99; gold[32'h103] = 8'h88;

    tbl[0]  = '{0, 2'd0, 1, 32'h103,  0,           0, 1, 32'hFFFFFF88};
    tbl[1]  = '{0, 2'd0, 0, 32'h101,  0,           0, 1, 32'h000000AA};
    tbl[2]  = '{0, 2'd1, 1, 32'h102,  0,           0, 1, 32'hFFFF8899};
    tbl[3]  = '{0, 2'd1, 0, 32'h100,  0,           0, 1, 32'h0000AABB};
    tbl[4]  = '{1, 2'd1, 0, 32'h102,  32'h1234,    0, 0, 32'h0};
    tbl[5]  = '{0, 2'd2, 0, 32'h100,  0,           0, 1, 32'h1234AABB};
    tbl[6]  = '{0, 2'd1, 1, 32'h101,  0,           1, 0, 32'h0};
    tbl[7]  = '{0, 2'd2, 0, 32'h102,  0,           1, 0, 32'h0};
    tbl[8]  = '{0, 2'd3, 0, 32'h100,  0,           1, 0, 32'h0};
    tbl[9]  = '{0, 2'd2, 0, 32'h2000, 0,           1, 0, 32'h0};
    tbl[10] = '{1, 2'd0, 0, 32'h1FFF, 32'hFFFFFFAB, 0, 0, 32'h0};
    tbl[11] = '{0, 2'd0, 1, 32'h1FFF, 0,           0, 1, 32'hFFFFFFAB};
    tbl[12] = '{0, 2'd0, 0, 32'h1FFF, 0,           0, 1, 32'h000000AB};

    repeat (2) @(negedge clk);
    step(1, 0, 0, 2'd0, 0, 32'd0, 32'd0);
    step(1, 1, 0, 2'd2, 0, 32'h100, 32'd0);

    // Reset during RMW_WRITE must drop the store.
    step(0, 1, 1, 2'd0, 0, 32'h100, 32'h55);
    step(1, 0, 0, 2'd0, 0, 32'd0, 32'd0);
    idle(1);
    run_req(0, 2'd2, 0, 32'h100, 0);
    chk("rst_rmw_word", seen_ld, 32'h8899AABB);

    // Load response coincides with accepting the next (sub-word store) request.
    step(0, 1, 0, 2'd2, 0, 32'h100, 0);
    idle(1);
    seen_lv = 0; seen_ld = 0;
    step(0, 1, 1, 2'd0, 0, 32'h100, 32'h77);
    chk("overlap_lv", {31'd0, seen_lv}, 32'd1);
    chk("overlap_ld", seen_ld, 32'h8899AABB);
    idle(3);
    run_req(0, 2'd2, 0, 32'h100, 0);
    chk("overlap_sb", seen_ld, 32'h8899AA77);
    run_req(1, 2'd2, 0, 32'h100, 32'h8899AABB);

    for (int i = 0; i < 13; i++) begin
      run_req(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd);
      chk($sformatf("tbl%0d_err", i), {31'd0, seen_err}, {31'd0, tbl[i].xerr});
      chk($sformatf("tbl%0d_lv", i), {31'd0, seen_lv}, {31'd0, tbl[i].xlv});
      if (tbl[i].xlv) chk($sformatf("tbl%0d_data", i), seen_ld, tbl[i].xd);
    end

    // Word store followed immediately by a sub-word store.
    step(0, 1, 1, 2'd2, 0, 32'h104, 32'hDEADBEEF);
    step(0, 1, 1, 2'd0, 0, 32'h105, 32'h11);
    idle(3);
    run_req(0, 2'd2, 0, 32'h104, 0);
    chk("sw_sb_word", seen_ld, 32'hDEAD11EF);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      sz = 2'($urandom_range(0, 3));
      a  = 32'h200 + $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0 && sz != 2'd3)
        a = a & ~((sz == 2'd0) ? 32'd0 : (sz == 2'd1) ? 32'd1 : 32'd3);
      if ($urandom_range(0, 15) == 0) a = 32'h2000 + $urandom_range(0, 255);
      step(0, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), sz,
           1'($urandom_range(0, 1)), a, $urandom);
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Sits between the EX/MEM pipeline register and the word-only data memory, which has a 1-cycle registered read and write-priority. It converts MIPS byte, halfword and word loads/stores into word accesses. Sub-word stores use a 2-cycle read-modify-write. Loads are extracted, sign- or zero-extended and returned in registered form. Misaligned and out-of-range accesses are flagged and no memory access is made for them.

Parameters:
MEM_BYTES, 8192, data memory size in bytes; any addr >= MEM_BYTES is out of range.
BIG_ENDIAN, 0, 0 = byte lane k occupies bits [8k+7:8k]; 1 = byte lane k occupies bits [31-8k:24-8k].

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
req_valid  in  1  access request from EX/MEM
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned in the low bits
ready  out  1  request accepted this cycle when req_valid && ready; the pipeline stalls while it is low
load_valid  out  1  registered; 1-cycle pulse carrying the load result
load_data  out  32  registered extended load result
err  out  1  registered; 1-cycle pulse for a misaligned, illegal-size or out-of-range request
mem_addr  out  32  to DMem address
mem_din  out  32  to DMem din
mem_read  out  1  to DMem read
mem_write  out  1  to DMem write
mem_dout  in  32  from DMem dout; valid the cycle after mem_read

Behaviour:
- FSM states: IDLE, LOAD_RESP, RMW_WRITE. ready = (state==IDLE) && !rst.
- On accept, the unit latches addr, size, signed and wdata.
- Error check at accept: half with addr[0]!=0, word with addr[1:0]!=0, size==11, or addr>=MEM_BYTES.
  - The request is consumed and err=1 the next cycle.
  - mem_read=mem_write=0, state stays IDLE.
- Word store in IDLE:
  - mem_write=1, mem_addr=req_addr, mem_din=req_wdata in the same cycle.
  - State stays IDLE; ready remains 1, so stores proceed back-to-back.
- Load in IDLE:
  - Accept cycle T: mem_read=1, mem_addr=req_addr, then go to LOAD_RESP.
  - T+1 (LOAD_RESP): extract the lane(s) of mem_dout selected by latched addr[1:0] and size, extend per signed, register into load_data. Go to IDLE.
  - T+2: load_valid=1 for exactly 1 cycle and load_data is valid. A new request may be accepted in T+2.
  - load_data holds its value until the next load response.
- Sub-word store (byte/half) in IDLE:
  - Accept cycle T: mem_read=1 at the latched address, then go to RMW_WRITE.
  - T+1: mem_write=1, mem_addr=latched addr, mem_din = mem_dout with only the target byte or half replaced by wdata[7:0] or wdata[15:0]. Go to IDLE.
  - ready is low for exactly 1 cycle.
- mem_din=0 whenever mem_write=0. mem_read and mem_write are never both 1.
- Memory-side outputs are combinational from state and latched or input request fields.
- Reset: when rst=1, state=IDLE; load_valid=0, load_data=0, err=0, and ready, mem_read and mem_write are all 0.
  - Reset dominates mid-operation: rst in RMW_WRITE suppresses the write, leaving memory unchanged.
  - rst in LOAD_RESP discards the response.
  - Latched request fields are cleared to 0.
- Any request with req_valid=0 leaves the FSM unchanged; the outputs are ignored while ready=0.

Decomposition:
- Package mips_mem_pkg holds:
  - the size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL;
  - the state encoding for IDLE/LOAD_RESP/RMW_WRITE;
  - MEM_BYTES_DEFAULT.
- One combinational sub-module, load_store_align, holds the lane extract plus extend (load path) and the lane merge (store path). It is parameterised by BIG_ENDIAN.

Test Plan:
1. DMem word 0x100=0x8899AABB, BIG_ENDIAN=0.
   - lb signed 0x103 -> load_valid at T+2, load_data=0xFFFFFF88.
   - lbu 0x101 -> 0x000000AA.
   - lh signed 0x102 -> 0xFFFF8899.
2. sh 0x102 wdata 0x00001234 -> T: mem_read=1; T+1: mem_write=1, mem_din=0x1234AABB, ready=0. A following lw 0x100 -> 0x1234AABB.
3. sw 0x104 0xDEADBEEF, then sb 0x105 0x11 the next cycle -> mem_write at T with 0xDEADBEEF, ready stays 1. RMW gives mem_din=0xDEAD11EF. lw 0x104 -> 0xDEAD11EF.
4. lh 0x101, lw 0x102, size=11, and lw 0x2000 -> each gives err=1 the next cycle, with no mem_read/mem_write and load_valid=0.
5. sb 0x100 0x55, with rst asserted in the RMW_WRITE cycle -> mem_write=0, word unchanged at 0x8899AABB. ready=0 during rst and 1 the cycle after rst falls.
6. lw 0x100 then sb 0x100 0x77 presented at T+2 -> load_valid and accept coincide. load_data=0x8899AABB; the later lw -> 0x8899AA77.
